// File: rtl/crc_frame_sequencer.sv
// Byte-stream sequencer for an external bit-serial CRC-CCITT LFSR engine.
// Issues the engine init, serialises bytes MSB-first and hands back the result.
module crc_frame_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             abort,
  output logic             crc_enable,
  output logic             crc_init,
  output logic             crc_data,
  input  logic [15:0]      crc_value,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_crc,
  output logic             res_zero,
  output logic [LEN_W-1:0] res_len
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOAD,
    SHIFT,
    RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      res_crc_q, res_crc_d;
  logic             res_zero_q, res_zero_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_q      <= '0;
      last_q     <= 1'b0;
      len_q      <= '0;
      res_crc_q  <= '0;
      res_zero_q <= 1'b0;
      res_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      len_q      <= len_d;
      res_crc_q  <= res_crc_d;
      res_zero_q <= res_zero_d;
      res_len_q  <= res_len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (s_valid) state_d = INIT;
      INIT:   state_d = abort ? IDLE : LOAD;
      LOAD: begin
        if (abort)        state_d = IDLE;
        else if (s_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)             state_d = IDLE;
        else if (bit_q == 3'd0) state_d = last_q ? RESULT : LOAD;
      end
      RESULT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sh_d       = sh_q;
    bit_d      = bit_q;
    last_d     = last_q;
    len_d      = len_q;
    res_crc_d  = res_crc_q;
    res_zero_d = res_zero_q;
    res_len_d  = res_len_q;
    unique case (state_q)
      INIT: len_d = '0;
      LOAD: begin
        if (s_valid && !abort) begin
          sh_d   = s_data;
          last_d = s_last;
          bit_d  = 3'd7;
          len_d  = (&len_q) ? len_q : len_q + 1'b1;
        end
      end
      SHIFT: begin
        if (!abort) begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q - 3'd1;
          if (bit_q == 3'd0 && last_q) res_len_d = len_q;
        end
      end
      RESULT: begin
        // Engine is idle here, so crc_value is the final frame CRC.
        res_crc_d  = crc_value;
        res_zero_d = (crc_value == 16'h0000);
      end
      default: ;
    endcase
  end

  always_comb begin
    s_ready    = 1'b0;
    crc_enable = 1'b0;
    crc_init   = 1'b0;
    crc_data   = 1'b0;
    res_valid  = 1'b0;
    res_crc    = res_crc_q;
    res_zero   = res_zero_q;
    res_len    = res_len_q;
    unique case (state_q)
      INIT: begin
        crc_enable = !abort;
        crc_init   = !abort;
      end
      LOAD:  s_ready = !abort;
      SHIFT: begin
        crc_enable = !abort;
        crc_data   = sh_q[7];
      end
      RESULT: begin
        res_valid = 1'b1;
        res_crc   = crc_value;
        res_zero  = (crc_value == 16'h0000);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// Randomised bench for crc_frame_sequencer with a behavioural LFSR engine
// and a bytewise CRC-CCITT reference model.
module tb_crc_frame_sequencer;

  localparam int LW = 4;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          s_last = 1'b0;
  logic          abort = 1'b0;
  logic          crc_enable;
  logic          crc_init;
  logic          crc_data;
  logic [15:0]   crc_value;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [15:0]   res_crc;
  logic          res_zero;
  logic [LW-1:0] res_len;

  int checks = 0;
  int failures = 0;

  int n_init = 0;
  int n_shift = 0;
  int en_load = 0;
  logic dq[$];

  logic [15:0] eng = 16'h0000;

  crc_frame_sequencer #(.LEN_W(LW)) dut (
    .clk(clk),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .abort(abort),
    .crc_enable(crc_enable),
    .crc_init(crc_init),
    .crc_data(crc_data),
    .crc_value(crc_value),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_crc(res_crc),
    .res_zero(res_zero),
    .res_len(res_len)
  );

  always #5 clk = ~clk;

  // Bit-serial CRC-CCITT engine, registered state.
  always @(posedge clk) begin
    if (crc_enable) begin
      if (crc_init) eng <= 16'hFFFF;
      else eng <= {eng[14:0], 1'b0} ^ ((eng[15] ^ crc_data) ? 16'h1021 : 16'h0000);
    end
  end
  assign crc_value = eng;

  always @(negedge clk) begin
    if (crc_enable && crc_init) n_init++;
    if (crc_enable && !crc_init) begin
      n_shift++;
      dq.push_back(crc_data);
    end
    if (s_ready && crc_enable) en_load++;
  end

  function automatic logic [15:0] ref_crc(input bq_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[k]) begin
      c = c ^ {q[k], 8'h00};
      for (int b = 0; b < 8; b++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic int ref_len(input int n);
    return (n > (2 ** LW) - 1) ? (2 ** LW) - 1 : n;
  endfunction

  function automatic bq_t digits();
    bq_t q;
    for (int k = 0; k < 9; k++) q.push_back(8'h31 + 8'(k));
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic clear_stats();
    n_init = 0;
    n_shift = 0;
    en_load = 0;
    dq.delete();
  endtask

  task automatic drive_frame(input bq_t q, input int gap, input int stop_at,
                             input bit use_rst, output bit got,
                             output logic stop_en);
    int i;
    int sh;
    int cyc;
    bit stopped;
    bit shift_now;
    i = 0;
    sh = 0;
    cyc = 0;
    stopped = 0;
    got = 0;
    stop_en = 1'bx;
    while (i < q.size() && !stopped && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      abort = 1'b0;
      #1;
      shift_now = crc_enable && !crc_init;
      if (stop_at >= 0 && shift_now && sh == stop_at) begin
        if (use_rst) reset = 1'b1;
        else abort = 1'b1;
        stopped = 1;
      end
      if (shift_now) sh++;
      if (gap == 0 || $urandom_range(0, gap) == 0) begin
        s_valid = 1'b1;
        s_data = q[i];
        s_last = (i == q.size() - 1);
      end else begin
        s_valid = 1'b0;
        s_data = 8'($urandom);
        s_last = 1'($urandom);
      end
      @(negedge clk);
      if (stopped) stop_en = crc_enable;
      if (s_valid && s_ready) i++;
    end
    checks++;
    if (cyc >= 2000) begin
      failures++;
      $display("FAIL drive_timeout got=%0d bytes exp=%0d", i, q.size());
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    reset = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    if (!stopped) begin
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (res_valid) got = 1;
      end
    end
  endtask

  task automatic ack(input string nm);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_ack res_valid=%b exp=0", nm, res_valid);
    end
  endtask

  task automatic check_result(input string nm, input bit got, input bq_t q);
    logic [15:0] e;
    e = ref_crc(q);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_no_result res_valid=0 exp=1", nm);
    end else if (res_crc !== e || res_zero !== (e == 16'h0) ||
                 res_len !== LW'(ref_len(q.size()))) begin
      failures++;
      $display("FAIL %s crc=%h zero=%b len=%0d exp crc=%h zero=%b len=%0d",
               nm, res_crc, res_zero, res_len, e, (e == 16'h0),
               ref_len(q.size()));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, crc_enable, crc_init, crc_data, res_valid, res_crc,
         res_zero, res_len} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b en=%b init=%b d=%b v=%b crc=%h z=%b len=%0d exp=all0",
               s_ready, crc_enable, crc_init, crc_data, res_valid, res_crc,
               res_zero, res_len);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_check_vector();
    bit got;
    logic se;
    clear_stats();
    drive_frame(digits(), 0, -1, 0, got, se);
    check_result("check_vector", got, digits());
    checks++;
    if (res_crc !== 16'h29B1) begin
      failures++;
      $display("FAIL check_vector_const crc=%h exp=29b1", res_crc);
    end
    checks++;
    if (n_init != 1 || n_shift != 72) begin
      failures++;
      $display("FAIL check_vector_pulses init=%0d shift=%0d exp init=1 shift=72",
               n_init, n_shift);
    end
    ack("check_vector");
    checks++;
    if (res_crc !== 16'h29B1 || res_len !== LW'(9) || res_zero !== 1'b0) begin
      failures++;
      $display("FAIL retain crc=%h len=%0d zero=%b exp crc=29b1 len=9 zero=0",
               res_crc, res_len, res_zero);
    end
  endtask

  task automatic test_residue();
    bit got;
    logic se;
    bq_t q;
    q = digits();
    q.push_back(8'h29);
    q.push_back(8'hB1);
    drive_frame(q, 0, -1, 0, got, se);
    check_result("residue", got, q);
    checks++;
    if (res_crc !== 16'h0000 || res_zero !== 1'b1 || res_len !== LW'(11)) begin
      failures++;
      $display("FAIL residue_const crc=%h zero=%b len=%0d exp crc=0000 zero=1 len=11",
               res_crc, res_zero, res_len);
    end
    ack("residue");
  endtask

  task automatic test_single_zero();
    bit got;
    logic se;
    bq_t q;
    int ones;
    q = '{8'h00};
    clear_stats();
    drive_frame(q, 0, -1, 0, got, se);
    check_result("single_zero", got, q);
    ones = 0;
    foreach (dq[k]) if (dq[k] !== 1'b0) ones++;
    checks++;
    if (dq.size() != 8 || ones != 0) begin
      failures++;
      $display("FAIL single_zero_bits count=%0d ones=%0d exp count=8 ones=0",
               dq.size(), ones);
    end
    ack("single_zero");
  endtask

  task automatic test_gaps();
    bit got;
    logic se;
    clear_stats();
    drive_frame(digits(), 3, -1, 0, got, se);
    check_result("gaps", got, digits());
    checks++;
    if (en_load != 0) begin
      failures++;
      $display("FAIL gaps_enable_in_load count=%0d exp=0", en_load);
    end
    ack("gaps");
  endtask

  task automatic test_backpressure();
    bit got;
    logic se;
    bq_t q;
    logic [15:0] c0;
    logic z0;
    logic [LW-1:0] l0;
    q = rand_bytes(3);
    drive_frame(q, 1, -1, 0, got, se);
    check_result("backpressure", got, q);
    c0 = res_crc;
    z0 = res_zero;
    l0 = res_len;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      s_valid = 1'b1;
      abort = 1'($urandom);
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || s_ready !== 1'b0 || crc_enable !== 1'b0 ||
          res_crc !== c0 || res_zero !== z0 || res_len !== l0) begin
        failures++;
        $display("FAIL backpressure_hold v=%b rdy=%b en=%b crc=%h len=%0d exp v=1 rdy=0 en=0 crc=%h len=%0d",
                 res_valid, s_ready, crc_enable, res_crc, res_len, c0, l0);
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    abort = 1'b0;
    ack("backpressure");
  endtask

  task automatic test_abort();
    bit got;
    logic se;
    int seen;
    drive_frame(digits(), 0, 19, 0, got, se);
    checks++;
    if (se !== 1'b0) begin
      failures++;
      $display("FAIL abort_enable crc_enable=%b exp=0", se);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_result res_valid_cycles=%0d exp=0", seen);
    end
    drive_frame(digits(), 0, -1, 0, got, se);
    check_result("after_abort", got, digits());
    ack("after_abort");
  endtask

  task automatic test_mid_reset();
    bit got;
    logic se;
    drive_frame(digits(), 0, 10, 1, got, se);
    @(negedge clk);
    checks++;
    if ({s_ready, crc_enable, crc_init, crc_data, res_valid, res_crc,
         res_zero, res_len} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs rdy=%b en=%b init=%b d=%b v=%b crc=%h z=%b len=%0d exp=all0",
               s_ready, crc_enable, crc_init, crc_data, res_valid, res_crc,
               res_zero, res_len);
    end
    drive_frame(digits(), 0, -1, 0, got, se);
    check_result("after_reset", got, digits());
    ack("after_reset");
  endtask

  task automatic test_saturation();
    bit got;
    logic se;
    bq_t q;
    q = rand_bytes(20);
    drive_frame(q, 0, -1, 0, got, se);
    check_result("saturation", got, q);
    ack("saturation");
  endtask

  task automatic test_random();
    bit got;
    logic se;
    bq_t q;
    logic [15:0] c;
    for (int f = 0; f < 6; f++) begin
      q = rand_bytes($urandom_range(1, 8));
      if ($urandom_range(0, 1) == 1) begin
        c = ref_crc(q);
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
      end
      drive_frame(q, $urandom_range(0, 2), -1, 0, got, se);
      check_result($sformatf("random_%0d", f), got, q);
      ack($sformatf("random_%0d", f));
    end
  endtask

  initial begin
    test_reset();
    test_check_vector();
    test_residue();
    test_single_zero();
    test_gaps();
    test_backpressure();
    test_abort();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
